// File: rtl/sprite_motion_ctrl.sv
// Frame-synchronous diagonal motion sequencer for one ROM-backed sprite block.
// Latency: oFrameTick one clock after the scan reaches (0,0); position/state update on the clock after that.
// Backpressure: none; the outputs are free-running and only change on frame ticks.
//
// Ports:
//   clk, reset             pixel clock, synchronous active-high reset
//   motion_en              request oscillation (low = return home and idle)
//   pow[10:5]              swing amplitude in steps (0..63)
//   iVGA_X / iVGA_Y        current scan position, used to find the start of a frame
//   pause                  only with SPRITE_MOTION_PAUSE_EN: freezes motion, ticks still reported
//   oTopLeftX / oTopLeftY  registered sprite top-left position
//   oFrameTick             one-cycle pulse per frame
//   oMoving / oState       activity flag and FSM state (IDLE=0 RUN_OUT=1 RUN_BACK=2 RETURN=3)
//
// Optional feature macro: SPRITE_MOTION_PAUSE_EN (adds the pause input).

module sprite_motion_ctrl #(
    parameter int X_INIT   = 280,
    parameter int Y_INIT   = 240,
    parameter int SPRITE_W = 31,
    parameter int STEP_DIV = 8,
    parameter int SCREEN_W = 640
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        motion_en,
    input  logic [10:0] pow,
    input  logic [9:0]  iVGA_X,
    input  logic [8:0]  iVGA_Y,
`ifdef SPRITE_MOTION_PAUSE_EN
    input  logic        pause,
`endif
    output logic [9:0]  oTopLeftX,
    output logic [8:0]  oTopLeftY,
    output logic        oFrameTick,
    output logic        oMoving,
    output logic [1:0]  oState
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN_OUT  = 2'd1,
        S_RUN_BACK = 2'd2,
        S_RETURN   = 2'd3
    } state_t;

    localparam logic [9:0] X_HOME = 10'(X_INIT);
    localparam logic [9:0] X_LIM  = 10'(SCREEN_W - 1 - SPRITE_W);
    localparam logic [8:0] Y_HOME = 9'(Y_INIT);

    // A divide-by-one still needs a one-bit counter so the compare stays legal.
    localparam int             DIV_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

    // Registers
    logic             r_origin_q;
    logic             r_frame_tick;
    state_t           r_state;
    logic [9:0]       r_x;
    logic [8:0]       r_y;
    logic [5:0]       r_step_cnt;
    logic [5:0]       r_amp;
    logic [DIV_W-1:0] r_div_cnt;

    // Next-state values
    state_t           w_state_nxt;
    logic [9:0]       w_x_nxt;
    logic [8:0]       w_y_nxt;
    logic [5:0]       w_step_nxt;
    logic [5:0]       w_amp_nxt;
    logic [DIV_W-1:0] w_div_nxt;

    logic       w_origin;
    logic       w_pause;
    logic       w_tick;
    logic       w_step;
    logic [5:0] w_new_amp;
    logic       w_unused_pow;

    assign w_origin     = (iVGA_X == 10'd0) && (iVGA_Y == 9'd0);
    assign w_new_amp    = pow[10:5];
    assign w_unused_pow = ^pow[4:0];

`ifdef SPRITE_MOTION_PAUSE_EN
    assign w_pause = pause;
`else
    assign w_pause = 1'b0;
`endif

    // Motion acts on the registered tick, so position changes land one clock
    // after the pulse becomes visible and always between frames.
    assign w_tick = r_frame_tick && !w_pause;
    assign w_step = w_tick && (r_div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_origin_q   <= 1'b0;
            r_frame_tick <= 1'b0;
            r_state      <= S_IDLE;
            r_x          <= X_HOME;
            r_y          <= Y_HOME;
            r_step_cnt   <= 6'd0;
            r_amp        <= 6'd0;
            r_div_cnt    <= '0;
        end else begin
            r_origin_q   <= w_origin;
            // Rising edge of origin only: a multi-clock dwell at (0,0) is one tick.
            r_frame_tick <= w_origin && !r_origin_q;
            r_state      <= w_state_nxt;
            r_x          <= w_x_nxt;
            r_y          <= w_y_nxt;
            r_step_cnt   <= w_step_nxt;
            r_amp        <= w_amp_nxt;
            r_div_cnt    <= w_div_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_step_nxt  = r_step_cnt;
        w_amp_nxt   = r_amp;
        w_div_nxt   = r_div_cnt;

        if (w_tick) begin
            if (r_state != S_IDLE) begin
                w_div_nxt = w_step ? '0 : r_div_cnt + DIV_W'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (motion_en && (w_new_amp != 6'd0)) begin
                        w_amp_nxt   = w_new_amp;
                        w_step_nxt  = 6'd0;
                        w_state_nxt = S_RUN_OUT;
                    end
                end

                S_RUN_OUT: begin
                    // Dropping motion_en wins over a step: position holds this tick.
                    if (!motion_en) begin
                        w_state_nxt = S_RETURN;
                    end else if (w_step) begin
                        if ((r_x >= X_LIM) || (r_y == 9'd0)) begin
                            w_state_nxt = S_RUN_BACK;
                            w_step_nxt  = 6'd0;
                        end else begin
                            w_x_nxt = r_x + 10'd1;
                            w_y_nxt = r_y - 9'd1;
                            if (r_step_cnt + 6'd1 == r_amp) begin
                                w_state_nxt = S_RUN_BACK;
                                w_step_nxt  = 6'd0;
                            end else begin
                                w_step_nxt = r_step_cnt + 6'd1;
                            end
                        end
                    end
                end

                S_RUN_BACK: begin
                    if (!motion_en) begin
                        w_state_nxt = S_RETURN;
                    end else if (w_step) begin
                        // A clamp taken right at home must not walk below X_INIT.
                        if (r_x != X_HOME) begin
                            w_x_nxt = r_x - 10'd1;
                            w_y_nxt = r_y + 9'd1;
                        end
                        if ((r_x == X_HOME) || (r_x - 10'd1 == X_HOME)) begin
                            // Back home: pick up the current amplitude for the next swing.
                            w_amp_nxt   = w_new_amp;
                            w_step_nxt  = 6'd0;
                            w_state_nxt = (w_new_amp == 6'd0) ? S_IDLE : S_RUN_OUT;
                        end
                    end
                end

                S_RETURN: begin
                    if (r_x == X_HOME) begin
                        w_state_nxt = S_IDLE;
                    end else if (w_step) begin
                        w_x_nxt = r_x - 10'd1;
                        w_y_nxt = r_y + 9'd1;
                        if (r_x - 10'd1 == X_HOME) begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end

                default: w_state_nxt = S_IDLE;
            endcase

            // IDLE always restarts the step phase from zero.
            if (w_state_nxt == S_IDLE) begin
                w_div_nxt = '0;
            end
        end
    end

    assign oTopLeftX  = r_x;
    assign oTopLeftY  = r_y;
    assign oFrameTick = r_frame_tick;
    assign oMoving    = (r_state != S_IDLE);
    assign oState     = r_state;

endmodule
